// File: rtl/fxp_divider.sv
// fxp_divider: sequential sign-magnitude Q(Q,N) restoring divider with start/busy/done handshake and saturation
module fxp_divider #(
  parameter int Q = 15,
  parameter int N = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [N-1:0] dividend,
  input  logic [N-1:0] divisor,
  output logic [N-1:0] quotient,
  output logic         done,
  output logic         busy,
  output logic         overflow
);
  localparam int NW = N - 1 + Q;
  localparam int CW = $clog2(NW);
  localparam logic [1:0] IDLE = 2'd0, CALC = 2'd1, FIN = 2'd2;
  logic [1:0]    state;
  logic [N-2:0]  b;
  logic [NW-1:0] num, acc;
  logic [N-1:0]  rem;
  logic [N:0]    rem_sh;
  logic [CW-1:0] cnt;
  logic          s, dz, ge, sat;
  logic [N-2:0]  mag;
  // rem_sh carries one spare bit so the compare never loses the shifted-out MSB
  always_comb begin
    rem_sh = {rem, num[NW-1]};
    ge     = rem_sh >= (N+1)'(b);
    sat    = dz || ((acc >> (N - 1)) != '0);
    mag    = sat ? '1 : acc[N-2:0];
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      b        <= '0;
      num      <= '0;
      acc      <= '0;
      rem      <= '0;
      cnt      <= '0;
      s        <= 1'b0;
      dz       <= 1'b0;
      quotient <= '0;
      done     <= 1'b0;
      busy     <= 1'b0;
      overflow <= 1'b0;
    end else begin
      done <= 1'b0;
      if (state == IDLE) begin
        if (start) begin
          num   <= NW'(dividend[N-2:0]) << Q;
          b     <= divisor[N-2:0];
          s     <= dividend[N-1] ^ divisor[N-1];
          dz    <= divisor[N-2:0] == '0;
          rem   <= '0;
          acc   <= '0;
          cnt   <= '0;
          busy  <= 1'b1;
          state <= (divisor[N-2:0] == '0) ? FIN : CALC;
        end
      end else if (state == CALC) begin
        rem   <= N'(ge ? rem_sh - (N+1)'(b) : rem_sh);
        acc   <= {acc[NW-2:0], ge};
        num   <= num << 1;
        cnt   <= cnt + 1'b1;
        state <= (cnt == CW'(NW - 1)) ? FIN : CALC;
      end else begin
        // a zero magnitude never carries a negative sign
        quotient <= {s && (mag != '0), mag};
        overflow <= sat;
        done     <= 1'b1;
        busy     <= 1'b0;
        state    <= IDLE;
      end
    end
  end
endmodule

// File: tb/tb_fxp_divider.sv
// tb_fxp_divider: randomized and directed self-checking bench for fxp_divider against an arithmetic model
module tb_fxp_divider;
  logic        clk = 1'b0, rst = 1'b1, start = 1'b0;
  logic [31:0] dividend = '0, divisor = '0;
  logic [31:0] quotient;
  logic        done, busy, overflow;
  int          checks = 0, errors = 0;

  fxp_divider #(.Q(15), .N(32)) dut (
    .clk(clk), .rst(rst), .start(start), .dividend(dividend), .divisor(divisor),
    .quotient(quotient), .done(done), .busy(busy), .overflow(overflow)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // returns {overflow, quotient}
  function automatic logic [32:0] model(input logic [31:0] x, input logic [31:0] y);
    logic [63:0] a, d, qq;
    logic        sg;
    a  = 64'(x[30:0]);
    d  = 64'(y[30:0]);
    sg = x[31] ^ y[31];
    if (d == 0) return {1'b1, sg, 31'h7fff_ffff};
    qq = (a * 64'd32768) / d;
    if (qq > 64'h7fff_ffff) return {1'b1, sg, 31'h7fff_ffff};
    return {1'b0, sg && (qq != 0), qq[30:0]};
  endfunction

  task automatic op_check(input string tag, input logic [31:0] x, input logic [31:0] y);
    logic [32:0] e;
    int lat, bc;
    e = model(x, y);
    @(negedge clk);
    dividend = x; divisor = y; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; dividend = $urandom; divisor = $urandom;
    lat = 0; bc = 0;
    while (!done && lat < 100) begin
      if (busy) bc++;
      @(posedge clk); #1;
      lat++;
    end
    check($sformatf("%s_q", tag), quotient, e[31:0]);
    check($sformatf("%s_ov", tag), overflow, e[32]);
    check($sformatf("%s_lat", tag), lat, (y[30:0] == 0) ? 1 : 47);
    check($sformatf("%s_busy", tag), bc, (y[30:0] == 0) ? 1 : 47);
    check($sformatf("%s_busy_low", tag), busy, 0);
    @(posedge clk); #1;
    check($sformatf("%s_pulse", tag), done, 0);
  endtask

  initial begin
    logic [31:0] x, y;
    logic [32:0] e;
    int t1, t2, n, cnt;
    repeat (3) @(negedge clk);
    check("rst_q", quotient, 0);
    check("rst_done", done, 0);
    check("rst_busy", busy, 0);
    check("rst_ov", overflow, 0);
    rst = 1'b0;

    op_check("six_by_two", 32'h0003_0000, 32'h0001_0000);
    op_check("neg", 32'h8000_C000, 32'h0000_4000);
    op_check("third", 32'h0000_8000, 32'h0001_8000);
    op_check("sat", 32'h7FFF_0000, 32'h0000_0001);
    op_check("divzero", 32'h0001_0000, 32'h8000_0000);
    op_check("zero", 32'h8000_0000, 32'h0001_0000);
    op_check("negzero_div", 32'h8001_0000, 32'h0000_0000);

    for (int i = 0; i < 24; i++) begin
      x = $urandom >> $urandom_range(0, 31);
      y = $urandom >> $urandom_range(0, 31);
      x[31] = 1'($urandom);
      y[31] = 1'($urandom);
      if (i % 8 == 0) y[30:0] = '0;
      op_check($sformatf("rnd%0d", i), x, y);
    end

    // start pulse mid-operation must be ignored
    e = model(32'h0005_0000, 32'h0002_0000);
    @(negedge clk);
    dividend = 32'h0005_0000; divisor = 32'h0002_0000; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    n = 0;
    while (!done && n < 100) begin
      if (n == 9) begin start = 1'b1; dividend = 32'h0001_0000; divisor = 32'h0000_0000; end
      if (n == 10) start = 1'b0;
      @(posedge clk); #1;
      n++;
    end
    check("midstart_lat", n, 47);
    check("midstart_q", quotient, e[31:0]);
    check("midstart_ov", overflow, e[32]);
    cnt = 0;
    repeat (60) begin @(posedge clk); #1; if (done) cnt++; end
    check("midstart_nodone", cnt, 0);

    // held start gives back-to-back results every 48 cycles
    @(negedge clk);
    dividend = 32'h0003_0000; divisor = 32'h0001_0000; start = 1'b1;
    @(posedge clk); #1;
    dividend = 32'h8000_C000; divisor = 32'h0000_4000;
    n = 0; t1 = -1; t2 = -1;
    while (t2 < 0 && n < 200) begin
      @(posedge clk); #1;
      n++;
      if (done) begin
        if (t1 < 0) begin
          t1 = n;
          check("b2b_q1", quotient, 32'h0001_8000);
        end else begin
          t2 = n;
          start = 1'b0;
          check("b2b_q2", quotient, 32'h8001_8000);
        end
      end
    end
    start = 1'b0;
    check("b2b_t1", t1, 47);
    check("b2b_gap", t2 - t1, 48);
    repeat (2) @(posedge clk);

    // asynchronous reset mid-operation
    @(negedge clk);
    dividend = 32'h0001_0000; divisor = 32'h0000_8000; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (20) @(posedge clk);
    #1 rst = 1'b1;
    #1;
    check("arst_q", quotient, 0);
    check("arst_busy", busy, 0);
    check("arst_done", done, 0);
    check("arst_ov", overflow, 0);
    repeat (3) @(negedge clk);
    rst = 1'b0;
    cnt = 0;
    repeat (60) begin @(posedge clk); #1; if (done) cnt++; end
    check("arst_nodone", cnt, 0);
    op_check("after_rst", 32'h0001_0000, 32'h0000_8000);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
